// File: rtl/fix_pkg.sv
// Shared constants and the builder state type for the FIX transmit path.
//   SOH, EQ, ASCII_ZERO : protocol byte values
//   fix_bld_state_t     : builder FSM states; each state names the kind of
//                         byte currently presented on data_o
package fix_pkg;
  localparam logic [7:0] SOH        = 8'h01;
  localparam logic [7:0] EQ         = 8'h3D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOH_LEAD,
    S_TAG,
    S_EQ,
    S_VALUE,
    S_DELIM,
    S_WAIT_FIELD,
    S_CK_TAG,
    S_CK_DIG,
    S_CK_SOH
  } fix_bld_state_t;
endpackage

// File: rtl/fix_cksum_ascii.sv
// Combinational 8-bit binary to three ASCII decimal digits, zero-filled
// (24 -> "0","2","4").
//   bin   : binary input 0..255
//   hund  : ASCII hundreds digit
//   tens  : ASCII tens digit
//   units : ASCII units digit
module fix_cksum_ascii
  import fix_pkg::*;
(
  input  logic [7:0] bin,
  output logic [7:0] hund,
  output logic [7:0] tens,
  output logic [7:0] units
);
  logic [7:0] q10;

  always_comb begin
    q10   = bin / 8'd10;
    hund  = ASCII_ZERO + (bin / 8'd100);
    tens  = ASCII_ZERO + (q10 % 8'd10);
    units = ASCII_ZERO + (bin % 8'd10);
  end
endmodule

// File: rtl/fix_msg_builder.sv
// FIX message serializer. Accepts one tag/value field per handshake and emits
// SOH, then "tag=value<SOH>" per field, then (optionally) "10=ddd<SOH>", one
// byte per cycle on a registered valid/ready stream.
// Build option: FIX_BUILDER_CHECKSUM_EN appends the checksum trailer and
// makes checksum_o / checksum_valid_o live; otherwise they are tied to 0.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   field_valid_i/ready_o, tag_i, value_i, field_last_i : field input
//   data_o, data_valid_o, data_ready_i                   : byte stream out
//   start_of_header_o  : leading SOH accepted (pulse)
//   end_of_message_o   : final SOH accepted (pulse)
//   busy_o             : message in progress
//   checksum_o, checksum_valid_o : running byte sum mod 256 and its valid
module fix_msg_builder
  import fix_pkg::*;
#(
  parameter int TAG_BYTES   = 4,
  parameter int VALUE_BYTES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     field_valid_i,
  output logic                     field_ready_o,
  input  logic [8*TAG_BYTES-1:0]   tag_i,
  input  logic [8*VALUE_BYTES-1:0] value_i,
  input  logic                     field_last_i,
  output logic [7:0]               data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     start_of_header_o,
  output logic                     end_of_message_o,
  output logic                     busy_o,
  output logic [7:0]               checksum_o,
  output logic                     checksum_valid_o
);
  localparam int TW = (TAG_BYTES   > 1) ? $clog2(TAG_BYTES)   : 1;
  localparam int VW = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;

  fix_bld_state_t state;

  logic [TAG_BYTES-1:0][7:0]   tag_r;
  logic [VALUE_BYTES-1:0][7:0] val_r;
  logic                        last_r;
  logic [TW-1:0]               tag_pos_r, tptr, tpos_in;
  logic [VW-1:0]               val_pos_r, vptr, vpos_in;
  logic                        val_zero_r, tag_zero_in, val_zero_in;
  logic [7:0]                  cksum;
  logic [7:0]                  ck_hund, ck_tens, ck_units;
  logic                        accept, adv, start_msg;

  assign accept    = field_valid_i & field_ready_o;
  assign adv       = data_valid_o & data_ready_i;
  assign start_msg = (state == S_IDLE) & accept & ~tag_zero_in;
  assign busy_o    = (state != S_IDLE);
  assign start_of_header_o = adv & (state == S_SOH_LEAD);

  // Position of the most significant nonzero byte; bytes above it are the
  // zero padding that is stripped on output.
  always_comb begin
    tpos_in     = '0;
    tag_zero_in = 1'b1;
    for (int i = 0; i < TAG_BYTES; i++) begin
      if (tag_i[8*i +: 8] != 8'h00) begin
        tpos_in     = TW'(i);
        tag_zero_in = 1'b0;
      end
    end
    vpos_in     = '0;
    val_zero_in = 1'b1;
    for (int i = 0; i < VALUE_BYTES; i++) begin
      if (value_i[8*i +: 8] != 8'h00) begin
        vpos_in     = VW'(i);
        val_zero_in = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_r      <= '0;
      val_r      <= '0;
      last_r     <= 1'b0;
      tag_pos_r  <= '0;
      val_pos_r  <= '0;
      val_zero_r <= 1'b0;
    end else if (accept) begin
      tag_r      <= tag_i;
      val_r      <= value_i;
      last_r     <= field_last_i;
      tag_pos_r  <= tpos_in;
      val_pos_r  <= vpos_in;
      val_zero_r <= val_zero_in;
    end
  end

  // Sum of every byte from the leading SOH through the last field's SOH;
  // trailer bytes are never added, so the value is frozen while they go out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cksum <= '0;
    else if (start_msg)
      cksum <= '0;
    else if (adv && (state inside {S_SOH_LEAD, S_TAG, S_EQ, S_VALUE, S_DELIM}))
      cksum <= cksum + data_o;
  end

  fix_cksum_ascii u_ck (
    .bin   (cksum),
    .hund  (ck_hund),
    .tens  (ck_tens),
    .units (ck_units)
  );

`ifdef FIX_BUILDER_CHECKSUM_EN
  logic [1:0] ck_idx;
  logic       ck_vld;

  assign end_of_message_o = adv & (state == S_CK_SOH);
  assign checksum_o       = cksum;
  assign checksum_valid_o = ck_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ck_vld <= 1'b0;
    else if (start_msg)
      ck_vld <= 1'b0;
    else if ((adv && state == S_DELIM && last_r) ||
             (state == S_WAIT_FIELD && accept && tag_zero_in && field_last_i))
      ck_vld <= 1'b1;
  end
`else
  logic unused_ck;
  assign unused_ck        = ^{ck_hund, ck_tens, ck_units};
  assign end_of_message_o = adv & (state == S_DELIM) & last_r;
  assign checksum_o       = '0;
  assign checksum_valid_o = 1'b0;
`endif

  // data_o always holds the byte of the current state; on acceptance the
  // next byte is loaded in the same edge, so there are no bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      field_ready_o <= 1'b0;
      tptr          <= '0;
      vptr          <= '0;
`ifdef FIX_BUILDER_CHECKSUM_EN
      ck_idx        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          field_ready_o <= 1'b1;
          if (accept && !tag_zero_in) begin
            state         <= S_SOH_LEAD;
            data_o        <= SOH;
            data_valid_o  <= 1'b1;
            field_ready_o <= 1'b0;
          end
        end
        S_WAIT_FIELD: begin
          if (accept) begin
            if (!tag_zero_in) begin
              state         <= S_TAG;
              data_o        <= tag_i[8*tpos_in +: 8];
              tptr          <= tpos_in;
              data_valid_o  <= 1'b1;
              field_ready_o <= 1'b0;
            end else if (field_last_i) begin
              // dropped last field: close the message that already started
`ifdef FIX_BUILDER_CHECKSUM_EN
              state         <= S_CK_TAG;
              data_o        <= 8'h31;
              ck_idx        <= '0;
              data_valid_o  <= 1'b1;
              field_ready_o <= 1'b0;
`else
              state         <= S_IDLE;
`endif
            end
          end
        end
        S_SOH_LEAD: if (adv) begin
          state  <= S_TAG;
          data_o <= tag_r[tag_pos_r];
          tptr   <= tag_pos_r;
        end
        S_TAG: if (adv) begin
          if (tptr == '0) begin
            state  <= S_EQ;
            data_o <= EQ;
          end else begin
            data_o <= tag_r[tptr - 1'b1];
            tptr   <= tptr - 1'b1;
          end
        end
        S_EQ: if (adv) begin
          if (val_zero_r) begin
            state  <= S_DELIM;
            data_o <= SOH;
          end else begin
            state  <= S_VALUE;
            data_o <= val_r[val_pos_r];
            vptr   <= val_pos_r;
          end
        end
        S_VALUE: if (adv) begin
          if (vptr == '0) begin
            state  <= S_DELIM;
            data_o <= SOH;
          end else begin
            data_o <= val_r[vptr - 1'b1];
            vptr   <= vptr - 1'b1;
          end
        end
        S_DELIM: if (adv) begin
          if (!last_r) begin
            state         <= S_WAIT_FIELD;
            data_valid_o  <= 1'b0;
            field_ready_o <= 1'b1;
          end else begin
`ifdef FIX_BUILDER_CHECKSUM_EN
            state  <= S_CK_TAG;
            data_o <= 8'h31;
            ck_idx <= '0;
`else
            state         <= S_IDLE;
            data_valid_o  <= 1'b0;
            field_ready_o <= 1'b1;
`endif
          end
        end
`ifdef FIX_BUILDER_CHECKSUM_EN
        // "1" is presented on entry; ck_idx tracks the byte on data_o
        S_CK_TAG: if (adv) begin
          case (ck_idx)
            2'd0:    data_o <= ASCII_ZERO;
            2'd1:    data_o <= EQ;
            default: data_o <= ck_hund;
          endcase
          if (ck_idx == 2'd2) begin
            state  <= S_CK_DIG;
            ck_idx <= '0;
          end else begin
            ck_idx <= ck_idx + 2'd1;
          end
        end
        S_CK_DIG: if (adv) begin
          case (ck_idx)
            2'd0:    data_o <= ck_tens;
            2'd1:    data_o <= ck_units;
            default: data_o <= SOH;
          endcase
          if (ck_idx == 2'd2) begin
            state  <= S_CK_SOH;
            ck_idx <= '0;
          end else begin
            ck_idx <= ck_idx + 2'd1;
          end
        end
        S_CK_SOH: if (adv) begin
          state         <= S_IDLE;
          data_valid_o  <= 1'b0;
          field_ready_o <= 1'b1;
        end
`endif
        default: begin
          state         <= S_IDLE;
          data_valid_o  <= 1'b0;
          field_ready_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fix_msg_builder.sv
// Directed bench for fix_msg_builder: a queue-based message model produces the
// expected byte stream and per-message checksum; one negedge monitor compares
// every accepted byte, stall stability, and end-of-message checksum.
module tb_fix_msg_builder;
`ifdef FIX_BUILDER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         field_valid_i = 1'b0;
  logic         field_ready_o;
  logic [31:0]  tag_i = '0;
  logic [255:0] value_i = '0;
  logic         field_last_i = 1'b0;
  logic [7:0]   data_o;
  logic         data_valid_o;
  logic         data_ready_i = 1'b1;
  logic         start_of_header_o, end_of_message_o, busy_o;
  logic [7:0]   checksum_o;
  logic         checksum_valid_o;

  fix_msg_builder #(.TAG_BYTES(4), .VALUE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .field_valid_i(field_valid_i), .field_ready_o(field_ready_o),
    .tag_i(tag_i), .value_i(value_i), .field_last_i(field_last_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .start_of_header_o(start_of_header_o), .end_of_message_o(end_of_message_o),
    .busy_o(busy_o), .checksum_o(checksum_o), .checksum_valid_o(checksum_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  tag;
    logic [255:0] val;
    bit           last;
  } fld_t;

  fld_t       msg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_ck_q[$];
  logic [7:0] mdl_bytes[$];
  int         mdl_ck;
  int         n_chk = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  int         rmode = 0;

  function automatic fld_t mk(input logic [31:0] t, input logic [255:0] v, input bit l);
    fld_t f;
    f.tag = t; f.val = v; f.last = l;
    return f;
  endfunction

  function automatic void emit(input logic [7:0] b);
    exp_q.push_back(b);
    mdl_bytes.push_back(b);
  endfunction

  function automatic void emit_str(input logic [255:0] v, input int n);
    bit seen = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (v[8*i +: 8] != 8'h00) seen = 1'b1;
      if (seen) emit(v[8*i +: 8]);
    end
  endfunction

  // Expected wire image of msg_q: strip padding, frame fields, append trailer.
  function automatic void model_build();
    bit    started = 1'b0;
    bit    eom = 1'b0;
    int    sum;
    string s;
    mdl_bytes.delete();
    mdl_ck = 0;
    foreach (msg_q[k]) begin
      if (msg_q[k].tag != 0) begin
        if (!started) begin emit(8'h01); started = 1'b1; end
        emit_str({224'b0, msg_q[k].tag}, 4);
        emit(8'h3D);
        emit_str(msg_q[k].val, 32);
        emit(8'h01);
        if (msg_q[k].last && !CK_EN) eom = 1'b1;
      end
      if (msg_q[k].last && started && CK_EN) begin
        sum = 0;
        foreach (mdl_bytes[j]) sum += int'(mdl_bytes[j]);
        mdl_ck = sum % 256;
        s = $sformatf("%03d", mdl_ck);
        emit(8'h31); emit(8'h30); emit(8'h3D);
        emit(s[0]); emit(s[1]); emit(s[2]);
        emit(8'h01);
        eom = 1'b1;
      end
    end
    if (eom) exp_ck_q.push_back(CK_EN ? 8'(mdl_ck) : 8'h00);
  endfunction

  task automatic send_field(input fld_t f);
    int n = 0;
    @(posedge clk); #1;
    field_valid_i = 1'b1; tag_i = f.tag; value_i = f.val; field_last_i = f.last;
    do begin @(negedge clk); n++; end while (!field_ready_o && n < 400);
    n_chk++;
    if (!field_ready_o) begin n_fail++; $display("FAIL field_handshake: ready=%0b after %0d cycles, required 1", field_ready_o, n); end
    @(posedge clk); #1;
    field_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || busy_o) && n < 1000);
    n_chk++;
    if (exp_q.size() != 0 || busy_o || exp_ck_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending bytes=%0d busy=%0b pending eom=%0d, required 0 0 0", name, exp_q.size(), busy_o, exp_ck_q.size());
    end
  endtask

  task automatic run_msg(input string name);
    model_build();
    foreach (msg_q[k]) send_field(msg_q[k]);
    wait_idle(name);
  endtask

  task automatic pin_bytes(input string name, input logic [7:0] lit[$]);
    bit ok = (lit.size() == mdl_bytes.size());
    if (ok) foreach (lit[i]) if (lit[i] !== mdl_bytes[i]) ok = 1'b0;
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_model_bytes: got %0d bytes, required %0d literal bytes", name, mdl_bytes.size(), lit.size()); end
  endtask

  // Sink ready: always 1, or toggling every cycle to exercise stalls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) data_ready_i = 1'b1;
      else            data_ready_i = ~data_ready_i;
    end
  end

  // Compare process: accepted bytes, stall hold, SOH/EOM pulses, busy drop.
  logic [7:0] prev_data;
  bit         prev_stall = 1'b0;
  bit         busy_chk = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
      busy_chk   = 1'b0;
    end else begin
      if (prev_stall) begin
        n_chk++;
        if (!(data_valid_o && data_o == prev_data)) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required 1 %02h", data_valid_o, data_o, prev_data);
        end
      end
      if (busy_chk) begin
        n_chk++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_drop: busy=%0b, required 0", busy_o); end
      end
      busy_chk = 1'b0;
      if (data_valid_o && data_ready_i) begin
        acc_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL byte_stream: extra byte %02h, none expected", data_o);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin n_fail++; $display("FAIL byte_stream: byte %02h, required %02h", data_o, e); end
        end
        if (start_of_header_o) begin
          n_chk++;
          if (data_o !== 8'h01) begin n_fail++; $display("FAIL sop_byte: byte %02h, required 01", data_o); end
        end
        if (end_of_message_o) begin
          busy_chk = 1'b1;
          n_chk++;
          if (exp_ck_q.size() == 0) begin
            n_fail++; $display("FAIL eom_pulse: unexpected end_of_message");
          end else begin
            e = exp_ck_q.pop_front();
            if (checksum_o !== e || checksum_valid_o !== CK_EN) begin
              n_fail++;
              $display("FAIL eom_checksum: ck=%02h vld=%0b, required %02h %0b", checksum_o, checksum_valid_o, e, CK_EN);
            end
          end
        end
      end
      prev_stall = data_valid_o && !data_ready_i;
      prev_data  = data_o;
    end
  end

  initial begin
    logic [7:0] lit[$];
    int base, n;

    // reset state
    repeat (3) @(negedge clk);
    n_chk++;
    if ({data_o, data_valid_o, field_ready_o, start_of_header_o, end_of_message_o, busy_o, checksum_o, checksum_valid_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: data=%02h vld=%0b rdy=%0b busy=%0b ck=%02h, required all 0", data_o, data_valid_o, field_ready_o, busy_o, checksum_o);
    end
    @(posedge clk); #1; rst = 1'b1;

    // 1: tag 35, value 8
    msg_q = '{};
    msg_q.push_back(mk(32'h3335, 256'h38, 1'b1));
    run_msg("t1");
    if (CK_EN) lit = '{8'h01,8'h33,8'h35,8'h3D,8'h38,8'h01,8'h31,8'h30,8'h3D,8'h32,8'h32,8'h33,8'h01};
    else       lit = '{8'h01,8'h33,8'h35,8'h3D,8'h38,8'h01};
    pin_bytes("t1", lit);
    n_chk++;
    if (CK_EN && mdl_ck != 8'hDF) begin n_fail++; $display("FAIL t1_model_ck: %0d, required 223", mdl_ck); end
    n_chk++;
    if (checksum_o !== (CK_EN ? 8'hDF : 8'h00)) begin n_fail++; $display("FAIL t1_final_ck: %02h, required %02h", checksum_o, CK_EN ? 8'hDF : 8'h00); end

    // 2: tag 9, value 178 -> checksum 24
    msg_q = '{};
    msg_q.push_back(mk("9", "178", 1'b1));
    run_msg("t2");
    if (CK_EN) lit = '{8'h01,8'h39,8'h3D,8'h31,8'h37,8'h38,8'h01,8'h31,8'h30,8'h3D,8'h30,8'h32,8'h34,8'h01};
    else       lit = '{8'h01,8'h39,8'h3D,8'h31,8'h37,8'h38,8'h01};
    pin_bytes("t2", lit);
    n_chk++;
    if (checksum_o !== (CK_EN ? 8'd24 : 8'd0)) begin n_fail++; $display("FAIL t2_final_ck: %02h, required %02h", checksum_o, CK_EN ? 8'd24 : 8'd0); end

    // 3: test 1 with a toggling sink
    rmode = 1;
    msg_q = '{};
    msg_q.push_back(mk(32'h3335, 256'h38, 1'b1));
    run_msg("t3");
    rmode = 0;

    // 4: multi-field message
    msg_q = '{};
    msg_q.push_back(mk("8", "FIX.4.2", 1'b0));
    msg_q.push_back(mk("35", "D", 1'b0));
    msg_q.push_back(mk("11", "ATOMNOCCC9990900", 1'b1));
    run_msg("t4");

    // 5: reset after three accepted bytes
    msg_q = '{};
    msg_q.push_back(mk("9", "ABCDEFGH", 1'b1));
    model_build();
    base = acc_cnt;
    send_field(msg_q[0]);
    n = 0;
    while (acc_cnt < base + 3 && n < 100) begin @(posedge clk); n++; end
    #2; rst = 1'b0;
    #1;
    n_chk++;
    if ({data_o, data_valid_o, field_ready_o, start_of_header_o, end_of_message_o, busy_o, checksum_o, checksum_valid_o} !== '0 || n >= 100) begin
      n_fail++; $display("FAIL t5_reset_outputs: data=%02h vld=%0b rdy=%0b busy=%0b ck=%02h cycles=%0d, required all 0", data_o, data_valid_o, field_ready_o, busy_o, checksum_o, n);
    end
    exp_q.delete();
    exp_ck_q.delete();
    @(negedge clk); rst = 1'b1;
    msg_q = '{};
    msg_q.push_back(mk(32'h3335, 256'h38, 1'b1));
    run_msg("t5");

    // 6a: all-zero value, then all-zero tag as last field
    msg_q = '{};
    msg_q.push_back(mk("35", 256'h0, 1'b0));
    msg_q.push_back(mk(32'h0, "X", 1'b1));
    run_msg("t6a");
    if (CK_EN) lit = '{8'h01,8'h33,8'h35,8'h3D,8'h01,8'h31,8'h30,8'h3D,8'h31,8'h36,8'h37,8'h01};
    else       lit = '{8'h01,8'h33,8'h35,8'h3D,8'h01};
    pin_bytes("t6a", lit);

    // 6b: lone all-zero tag field: accepted, nothing emitted
    msg_q = '{};
    msg_q.push_back(mk(32'h0, "77", 1'b1));
    base = acc_cnt;
    run_msg("t6b");
    n_chk++;
    if (acc_cnt != base || busy_o !== 1'b0) begin n_fail++; $display("FAIL t6b_silent: bytes=%0d busy=%0b, required 0 0", acc_cnt - base, busy_o); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
